prt_vtb_tg_ctl: RTL and testbench

// Configuration sequencer for the video toolbox timing generator (TG).
// - Holds host-written shadow timing parameters and range-checks them.
// - Stops the TG, streams the parameters over its VPS write port (indices 4..11), waits for its derived-timing pipeline, then restarts it.
// - Restart is free-running, or aligned to an external sync (sync mode).
// - Sits between the host register interface / policy processor and the TG.
//

---
 rtl/prt_vtb_pkg.sv | 40 ++++
 rtl/prt_dp_lib_edge.sv | 18 +
 rtl/prt_vtb_tg_ctl.sv | 182 ++++++++++++++++++
 tb/tb_prt_vtb_tg_ctl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prt_vtb_pkg.sv
// Shared types for the video toolbox timing-generator control slice.
// State encoding, TG VPS parameter indices and the timing-set layout.
package prt_vtb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_STOP,
        ST_LOAD,
        ST_SETTLE,
        ST_ARM,
        ST_RUN,
        ST_ERR
    } tg_state_t;

    localparam logic [3:0] VPS_HTOTAL  = 4'd4;
    localparam logic [3:0] VPS_HWIDTH  = 4'd5;
    localparam logic [3:0] VPS_HSTART  = 4'd6;
    localparam logic [3:0] VPS_HSW     = 4'd7;
    localparam logic [3:0] VPS_VTOTAL  = 4'd8;
    localparam logic [3:0] VPS_VHEIGHT = 4'd9;
    localparam logic [3:0] VPS_VSTART  = 4'd10;
    localparam logic [3:0] VPS_VSW     = 4'd11;

    typedef struct packed {
        logic [15:0] htotal;
        logic [15:0] hwidth;
        logic [15:0] hstart;
        logic [15:0] hsw;
        logic [15:0] vtotal;
        logic [15:0] vheight;
        logic [15:0] vstart;
        logic [15:0] vsw;
    } tg_set_t;

    function automatic logic [3:0] vps_idx(input logic [2:0] i_word);
        return VPS_HTOTAL + {1'b0, i_word};
    endfunction

endpackage

// File: rtl/prt_dp_lib_edge.sv
// Rising-edge detector: one-cycle pulse when D_IN goes from 0 to 1.
module prt_dp_lib_edge (
    input  logic CLK_IN,
    input  logic RST_IN,
    input  logic D_IN,
    output logic RISE_OUT
);

    logic r_d;

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) r_d <= 1'b0;
        else        r_d <= D_IN;
    end

    assign RISE_OUT = D_IN & ~r_d;

endmodule

// File: rtl/prt_vtb_tg_ctl.sv
// TG configuration sequencer: range-checks the shadow timing set, stops the
// TG, streams the set over VPS, waits for timing derivation, then restarts.
module prt_vtb_tg_ctl
    import prt_vtb_pkg::*;
#(
    parameter int unsigned P_PPC    = 2,
    parameter int unsigned P_STOP   = 4,
    parameter int unsigned P_SETTLE = 4
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic [2:0]  HOST_IDX_IN,
    input  logic [15:0] HOST_DAT_IN,
    input  logic        HOST_WR_IN,
    input  logic        HOST_EN_IN,
    input  logic        HOST_MODE_IN,
    input  logic        HOST_UPD_IN,
    input  logic        SYNC_IN,
    output logic [3:0]  VPS_IDX_OUT,
    output logic [15:0] VPS_DAT_OUT,
    output logic        VPS_VLD_OUT,
    output logic        CTL_RUN_OUT,
    output logic        CTL_MODE_OUT,
    output logic        STA_BUSY_OUT,
    output logic        STA_RUN_OUT,
    output logic        STA_ERR_OUT
);

    localparam logic [3:0]  LP_STOP   = 4'(P_STOP - 1);
    localparam logic [3:0]  LP_SETTLE = 4'(P_SETTLE - 1);
    localparam logic [15:0] LP_PPC    = 16'(P_PPC);

    tg_state_t         r_st;
    tg_state_t         w_nxt;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nxt;
    logic [0:7][15:0]  r_shadow;
    logic [0:7][15:0]  r_work;
    tg_set_t           w_set;
    logic              r_wmode;
    logic              r_mode;
    logic              r_run;
    logic              r_err;
    logic              r_pend;
    logic              r_sync;
    logic              w_sync_rise;
    logic              w_snap;
    logic              w_busy;
    logic              w_ok;
    logic              w_vld;
    logic [2:0]        w_widx;
    logic [16:0]       w_ht, w_hw, w_hs, w_hsw;
    logic [16:0]       w_vt, w_vh, w_vs, w_vsw;

    prt_dp_lib_edge u_sync_edge (
        .CLK_IN   (CLK_IN),
        .RST_IN   (RST_IN),
        .D_IN     (r_sync),
        .RISE_OUT (w_sync_rise)
    );

    assign w_set = tg_set_t'(r_work);
    assign w_ht  = {1'b0, w_set.htotal};
    assign w_hw  = {1'b0, w_set.hwidth};
    assign w_hs  = {1'b0, w_set.hstart};
    assign w_hsw = {1'b0, w_set.hsw};
    assign w_vt  = {1'b0, w_set.vtotal};
    assign w_vh  = {1'b0, w_set.vheight};
    assign w_vs  = {1'b0, w_set.vstart};
    assign w_vsw = {1'b0, w_set.vsw};

    // Start+width compared as a sum so no subtraction can wrap.
    assign w_ok = (w_hw != '0) && (w_ht > w_hw) && (w_hs + w_hw <= w_ht)
               && (w_hsw != '0) && (w_hs >= w_hsw)
               && (w_vh != '0) && (w_vt > w_vh) && (w_vs + w_vh <= w_vt)
               && (w_vsw != '0) && (w_vs >= w_vsw)
               && (w_set.htotal % LP_PPC == '0)
               && (w_set.hwidth % LP_PPC == '0);

    assign w_busy = r_st inside {ST_CHECK, ST_STOP, ST_LOAD, ST_SETTLE, ST_ARM};

    always_comb begin
        w_nxt     = r_st;
        w_cnt_nxt = r_cnt;
        w_snap    = 1'b0;
        if (!HOST_EN_IN) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_st)
                ST_IDLE: begin
                    if (HOST_UPD_IN) begin
                        w_nxt  = ST_CHECK;
                        w_snap = 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_ok) begin
                        w_nxt     = ST_STOP;
                        w_cnt_nxt = LP_STOP;
                    end else begin
                        w_nxt = ST_ERR;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == '0) begin
                        w_nxt     = ST_LOAD;
                        w_cnt_nxt = 4'd7;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_LOAD: begin
                    if (r_cnt == '0) begin
                        w_nxt     = ST_SETTLE;
                        w_cnt_nxt = LP_SETTLE;
                    end else begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) w_nxt = ST_ARM;
                    else             w_cnt_nxt = r_cnt - 4'd1;
                end
                ST_ARM: begin
                    if (!r_wmode || w_sync_rise) w_nxt = ST_RUN;
                end
                ST_RUN, ST_ERR: begin
                    if (r_pend || HOST_UPD_IN) begin
                        w_nxt  = ST_CHECK;
                        w_snap = 1'b1;
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            r_st     <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_work   <= '0;
            r_wmode  <= 1'b0;
            r_mode   <= 1'b0;
            r_run    <= 1'b0;
            r_err    <= 1'b0;
            r_pend   <= 1'b0;
            r_sync   <= 1'b0;
        end else begin
            r_st   <= w_nxt;
            r_cnt  <= w_cnt_nxt;
            r_sync <= SYNC_IN;
            if (HOST_WR_IN) r_shadow[HOST_IDX_IN] <= HOST_DAT_IN;
            if (w_snap) begin
                r_work  <= r_shadow;
                r_wmode <= HOST_MODE_IN;
            end
            if (!HOST_EN_IN)                r_pend <= 1'b0;
            else if (w_busy && HOST_UPD_IN) r_pend <= 1'b1;
            else if (w_snap)                r_pend <= 1'b0;
            // Run survives only the CHECK that directly follows RUN.
            r_run <= (w_nxt == ST_RUN) || ((w_nxt == ST_CHECK) && r_run);
            if (w_nxt == ST_ERR)        r_err <= 1'b1;
            else if (w_nxt == ST_CHECK) r_err <= 1'b0;
            if (r_st == ST_SETTLE) r_mode <= r_wmode;
        end
    end

    assign w_vld  = (r_st == ST_LOAD);
    assign w_widx = 3'(4'd7 - r_cnt);

    assign VPS_VLD_OUT  = w_vld;
    assign VPS_IDX_OUT  = w_vld ? vps_idx(w_widx) : '0;
    assign VPS_DAT_OUT  = w_vld ? r_work[w_widx] : '0;
    assign CTL_RUN_OUT  = r_run;
    assign CTL_MODE_OUT = r_mode;
    assign STA_BUSY_OUT = w_busy;
    assign STA_RUN_OUT  = (r_st == ST_RUN);
    assign STA_ERR_OUT  = r_err;

endmodule

// File: tb/tb_prt_vtb_tg_ctl.sv
// Bench for prt_vtb_tg_ctl: vector table, hand sequences for multi-cycle
// corners, and random timing sets checked against a rule-level model.
module tb_prt_vtb_tg_ctl;

    localparam int P_PPC    = 2;
    localparam int P_STOP   = 4;
    localparam int P_SETTLE = 4;
    localparam int LAT      = 1 + 1 + P_STOP + 8 + P_SETTLE + 1;

    logic        clk = 1'b0;
    logic        rst, hwr, en, mode, upd, sync;
    logic [2:0]  hidx;
    logic [15:0] hdat;
    logic [3:0]  vidx;
    logic [15:0] vdat;
    logic        vvld, crun, cmode, busy, srun, err;

    always #5 clk = ~clk;

    prt_vtb_tg_ctl #(.P_PPC(P_PPC), .P_STOP(P_STOP), .P_SETTLE(P_SETTLE)) dut (
        .CLK_IN(clk), .RST_IN(rst), .HOST_IDX_IN(hidx), .HOST_DAT_IN(hdat),
        .HOST_WR_IN(hwr), .HOST_EN_IN(en), .HOST_MODE_IN(mode),
        .HOST_UPD_IN(upd), .SYNC_IN(sync), .VPS_IDX_OUT(vidx),
        .VPS_DAT_OUT(vdat), .VPS_VLD_OUT(vvld), .CTL_RUN_OUT(crun),
        .CTL_MODE_OUT(cmode), .STA_BUSY_OUT(busy), .STA_RUN_OUT(srun),
        .STA_ERR_OUT(err)
    );

    typedef struct packed {
        logic [0:7][15:0] s;
        logic             ok;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    int   n_bad_idle = 0;
    int   cyc;
    int   q_idx[$], q_dat[$], q_cyc[$], q_rise[$];
    logic prev_run;
    vec_t tbl[13];

    function automatic logic [0:7][15:0] mk(input int a, b, c, d, e, f, g, h);
        return {16'(a), 16'(b), 16'(c), 16'(d), 16'(e), 16'(f), 16'(g), 16'(h)};
    endfunction

    // Acceptance rules evaluated on plain 32-bit integers.
    function automatic bit model_ok(input logic [0:7][15:0] s);
        int ht, hw, hs, hsw, vt, vh, vs, vsw;
        ht = int'(s[0]); hw = int'(s[1]); hs = int'(s[2]); hsw = int'(s[3]);
        vt = int'(s[4]); vh = int'(s[5]); vs = int'(s[6]); vsw = int'(s[7]);
        return hw > 0 && ht > hw && hs <= ht - hw && hsw > 0 && hs >= hsw
            && vh > 0 && vt > vh && vs <= vt - vh && vsw > 0 && vs >= vsw
            && ht % P_PPC == 0 && hw % P_PPC == 0;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic obs;
        tick;
        cyc++;
        if (vvld) begin
            q_idx.push_back(int'(vidx));
            q_dat.push_back(int'(vdat));
            q_cyc.push_back(cyc);
        end else if (vidx != '0 || vdat != '0) begin
            n_bad_idle++;
        end
        if (crun && !prev_run) q_rise.push_back(cyc);
        prev_run = crun;
    endtask

    task automatic clr;
        q_idx.delete(); q_dat.delete(); q_cyc.delete(); q_rise.delete();
        cyc = 0;
        prev_run = crun;
    endtask

    task automatic wr_sh(input logic [0:7][15:0] s);
        for (int i = 0; i < 8; i++) begin
            hidx = 3'(i); hdat = s[i]; hwr = 1'b1;
            tick;
        end
        hwr = 1'b0;
    endtask

    task automatic idle_en;
        en = 1'b0; tick; en = 1'b1;
    endtask

    task automatic check_stream(input string nm, input logic [0:7][15:0] s,
                                input int base);
        if (q_idx.size() < base + 8) begin
            chk({nm, "_nwr"}, q_idx.size(), base + 8);
        end else begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("%s_idx%0d", nm, i), q_idx[base+i], 4 + i);
                chk($sformatf("%s_dat%0d", nm, i), q_dat[base+i], int'(s[i]));
                chk($sformatf("%s_cyc%0d", nm, i), q_cyc[base+i] - q_cyc[base], i);
            end
        end
    endtask

    task automatic check_result(input string nm, input logic [0:7][15:0] s,
                                input bit ok);
        chk({nm, "_err"}, int'(err), ok ? 0 : 1);
        chk({nm, "_nwr"}, q_idx.size(), ok ? 8 : 0);
        chk({nm, "_rise"}, q_rise.size() > 0 ? q_rise[0] : -1, ok ? LAT : -1);
        if (ok) check_stream(nm, s, 0);
    endtask

    task automatic run_upd(input logic [0:7][15:0] s, input logic m);
        idle_en;
        wr_sh(s);
        mode = m;
        clr;
        upd = 1'b1; obs; upd = 1'b0;
        repeat (LAT + 4) obs;
    endtask

    logic [0:7][15:0] base_s, new_s, rs;
    int j, v;
    bit same_wr;

    initial begin
        rst = 1'b1; hwr = 0; en = 0; mode = 0; upd = 0; sync = 0;
        hidx = '0; hdat = '0;
        base_s = mk(2200, 1920, 192, 44, 1125, 1080, 41, 5);
        tbl[0]  = '{s: base_s, ok: 1'b1};
        tbl[1]  = '{s: mk(1920, 1920, 192, 44, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[2]  = '{s: mk(2201, 1920, 192, 44, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[3]  = '{s: mk(2200, 1920, 280, 44, 1125, 1080, 41, 5), ok: 1'b1};
        tbl[4]  = '{s: mk(2200, 1920, 281, 44, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[5]  = '{s: mk(2200, 1920, 44, 44, 1125, 1080, 41, 5), ok: 1'b1};
        tbl[6]  = '{s: mk(2200, 1920, 43, 44, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[7]  = '{s: mk(2200, 1920, 192, 0, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[8]  = '{s: mk(2200, 1920, 192, 44, 1125, 1080, 45, 5), ok: 1'b1};
        tbl[9]  = '{s: mk(2200, 1920, 192, 44, 1125, 1080, 46, 5), ok: 1'b0};
        tbl[10] = '{s: mk(2200, 1921, 192, 44, 1125, 1080, 41, 5), ok: 1'b0};
        tbl[11] = '{s: mk(2200, 1920, 192, 44, 1125, 0, 41, 5), ok: 1'b0};
        tbl[12] = '{s: mk(2200, 1920, 65535, 44, 1125, 1080, 41, 5), ok: 1'b0};

        repeat (2) tick;
        rst = 1'b0;
        chk("rst_outs", int'({vvld, vidx, vdat, crun, cmode, busy, srun, err}), 0);
        upd = 1'b1; tick; upd = 1'b0;
        chk("upd_no_en_busy", int'(busy), 0);

        for (int i = 0; i < 13; i++) begin
            run_upd(tbl[i].s, 1'b0);
            check_result($sformatf("vec%0d", i), tbl[i].s, tbl[i].ok);
        end

        // Error set, then a valid set straight from ERR.
        run_upd(tbl[1].s, 1'b0);
        chk("err_set", int'(err), 1);
        chk("err_run", int'(crun), 0);
        wr_sh(base_s);
        clr;
        upd = 1'b1; obs; upd = 1'b0;
        chk("err_clr_check", int'(err), 0);
        chk("err_clr_busy", int'(busy), 1);
        repeat (LAT + 2) obs;
        check_result("from_err", base_s, 1'b1);

        // Sync mode: early edge discarded, late edge starts the TG.
        idle_en; wr_sh(base_s); mode = 1'b1; clr;
        for (int k = 0; k < 60; k++) begin
            upd  = (k == 0);
            sync = (k >= 5 && k < 8) || (k >= 40);
            obs;
            if (cyc == 40) begin
                chk("sync_mode_pre", int'(cmode), 1);
                chk("sync_run_pre", int'(crun), 0);
            end
        end
        sync = 1'b0; mode = 1'b0;
        chk("sync_rise", q_rise.size() > 0 ? q_rise[0] : -1, 42);
        check_stream("sync", base_s, 0);

        // Two UPDs from RUN with vtotal changed between them.
        run_upd(base_s, 1'b0);
        chk("r4_pre_run", int'(srun), 1);
        new_s = base_s; new_s[4] = 16'd1200;
        clr;
        for (int k = 0; k < 45; k++) begin
            upd  = (k == 0 || k == 6);
            hwr  = (k == 3); hidx = 3'd4; hdat = 16'd1200;
            obs;
        end
        upd = 1'b0; hwr = 1'b0;
        chk("r4_nwr", q_idx.size(), 16);
        check_stream("r4_a", base_s, 0);
        check_stream("r4_b", new_s, 8);
        chk("r4_nrise", q_rise.size(), 2);
        chk("r4_rise2", q_rise.size() > 1 ? q_rise[1] : -1, 38);
        chk("r4_end_run", int'(crun), 1);

        // EN dropped mid-LOAD, then a full reload.
        idle_en; wr_sh(base_s); clr;
        for (int k = 0; k < 8; k++) begin
            upd = (k == 0);
            obs;
        end
        upd = 1'b0;
        chk("abort_nwr", q_idx.size(), 3);
        en = 1'b0; obs;
        chk("abort_vld", int'(vvld), 0);
        chk("abort_run", int'(crun), 0);
        chk("abort_busy", int'(busy), 0);
        en = 1'b1; clr;
        upd = 1'b1; obs; upd = 1'b0;
        repeat (LAT + 2) obs;
        check_result("reload", base_s, 1'b1);

        // Reset during SETTLE.
        idle_en; wr_sh(base_s); mode = 1'b1; clr;
        for (int k = 0; k < 15; k++) begin
            upd = (k == 0);
            obs;
        end
        upd = 1'b0;
        chk("settle_busy", int'(busy), 1);
        chk("settle_mode", int'(cmode), 1);
        rst = 1'b1; tick; rst = 1'b0; mode = 1'b0;
        chk("rst_mid", int'({vvld, vidx, vdat, crun, cmode, busy, srun, err}), 0);

        // Random sets against the rule model.
        for (int n = 0; n < 30; n++) begin
            int ht;
            ht = int'($urandom_range(4, 64));
            rs[0] = 16'(ht);
            rs[1] = 16'($urandom_range(0, ht + 2));
            rs[2] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, ht));
            rs[3] = 16'($urandom_range(0, int'(rs[2]) % 70 + 1));
            rs[4] = 16'($urandom_range(4, 64));
            rs[5] = 16'($urandom_range(0, int'(rs[4]) + 1));
            rs[6] = 16'($urandom_range(0, int'(rs[4])));
            rs[7] = 16'($urandom_range(0, int'(rs[6]) + 1));
            same_wr = 1'($urandom_range(0, 1));
            j = int'($urandom_range(0, 7));
            v = int'($urandom_range(0, 65535));
            idle_en; wr_sh(rs); mode = 1'b0; clr;
            upd = 1'b1;
            if (same_wr) begin
                hwr = 1'b1; hidx = 3'(j); hdat = 16'(v);
            end
            obs;
            upd = 1'b0; hwr = 1'b0;
            repeat (LAT + 3) obs;
            check_result($sformatf("rnd%0d", n), rs, model_ok(rs));
        end

        chk("idle_vps_zero", n_bad_idle, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
